// File: rtl/multicycle_control.sv
// Multicycle Moore sequencer: fetch/decode/execute/memory/writeback over a shared req/ack memory port.
// Optional memory-wait watchdog enabled by defining MC_WATCHDOG_EN.
module multicycle_control #(
  parameter int RET_W       = 32,
  parameter int WDOG_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic             mem_ack,
  input  logic             cond_le,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             irWrite,
  output logic             pcWrite,
  output logic [1:0]       pcSrc,
  output logic             regWriteEnable,
  output logic             regDst,
  output logic             memToReg,
  output logic             ALUSrc,
  output logic [4:0]       ALUControl,
  output logic             link,
  output logic             illegal,
  output logic [RET_W-1:0] retired,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_JUMP   = 3'd6;
  localparam logic [2:0] S_BRANCH = 3'd7;

  localparam logic [5:0] OP_AND  = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_NOR  = 6'b100110;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_NOT  = 6'b000100;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_ROTV = 6'b000010;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_AND, OP_LW, OP_SW, OP_JR, OP_JAL, OP_NOR,
      OP_NORI, OP_NOT, OP_BLEU, OP_ROLV, OP_ROTV: op_legal = 1'b1;
      default:                                    op_legal = 1'b0;
    endcase
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       next_state_s;
  logic [5:0]       op_r;
  logic [RET_W-1:0] retired_r;
  logic             retire_s;
  logic             timeout_s;
  logic             waiting_s;
  logic             ins_unused_s;

  assign ins_unused_s = ^ins[25:0];
  assign waiting_s    = (state_r == S_FETCH) || (state_r == S_MEM);

`ifdef MC_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1) + 1;
  logic [WD_W-1:0] wdog_cnt_r;

  // Wait counter: cleared on every state change or timeout, counts cycles without ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt_r <= {WD_W{1'b0}};
    end else if ((state_r != next_state_s) || timeout_s) begin
      wdog_cnt_r <= {WD_W{1'b0}};
    end else if (waiting_s && !mem_ack) begin
      wdog_cnt_r <= wdog_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
    end else begin
      wdog_cnt_r <= wdog_cnt_r;
    end
  end

  // An ack in the timeout cycle takes priority.
  assign timeout_s = waiting_s && !mem_ack && (wdog_cnt_r == WD_W'(WDOG_CYCLES));
`else
  localparam int wdog_unused_p = WDOG_CYCLES;
  assign timeout_s = 1'b0;
`endif

  // State, latched opcode and retired counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      op_r      <= 6'd0;
      retired_r <= {RET_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if ((state_r == S_FETCH) && mem_ack) begin
        op_r <= ins[31:26];
      end else begin
        op_r <= op_r;
      end
      if (retire_s) begin
        retired_r <= retired_r + {{(RET_W-1){1'b0}}, 1'b1};
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = S_IDLE;
    case (state_r)
      S_IDLE:   next_state_s = S_FETCH;
      S_FETCH:  next_state_s = mem_ack ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!op_legal(op_r)) begin
          next_state_s = S_FETCH;
        end else if ((op_r == OP_JR) || (op_r == OP_JAL)) begin
          next_state_s = S_JUMP;
        end else if (op_r == OP_BLEU) begin
          next_state_s = S_BRANCH;
        end else begin
          next_state_s = S_EXEC;
        end
      end
      S_EXEC:   next_state_s = ((op_r == OP_LW) || (op_r == OP_SW)) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ack) begin
          next_state_s = (op_r == OP_LW) ? S_WB : S_FETCH;
        end else if (timeout_s) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM;
        end
      end
      S_WB, S_JUMP, S_BRANCH: next_state_s = S_FETCH;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Moore output decode; FETCH load strobes are qualified by the ack.
  always_comb begin
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    iord           = 1'b0;
    irWrite        = 1'b0;
    pcWrite        = 1'b0;
    pcSrc          = 2'd0;
    regWriteEnable = 1'b0;
    regDst         = 1'b0;
    memToReg       = 1'b0;
    ALUSrc         = 1'b0;
    ALUControl     = 5'd0;
    link           = 1'b0;
    illegal        = 1'b0;
    retire_s       = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req = !timeout_s;
        illegal = timeout_s;
        irWrite = mem_ack;
        pcWrite = mem_ack;
      end
      S_DECODE: illegal = !op_legal(op_r);
      S_EXEC: begin
        ALUControl = op_r[5:1];
        ALUSrc     = (op_r == OP_LW) || (op_r == OP_SW) || (op_r == OP_NORI);
      end
      S_MEM: begin
        mem_req    = !timeout_s;
        illegal    = timeout_s;
        iord       = 1'b1;
        mem_we     = (op_r == OP_SW) && !timeout_s;
        ALUControl = op_r[5:1];
        retire_s   = mem_ack && (op_r == OP_SW);
      end
      S_WB: begin
        regWriteEnable = 1'b1;
        regDst         = (op_r != OP_LW) && (op_r != OP_NORI);
        memToReg       = (op_r == OP_LW);
        retire_s       = 1'b1;
      end
      S_JUMP: begin
        pcWrite        = 1'b1;
        pcSrc          = (op_r == OP_JAL) ? 2'd3 : 2'd2;
        regWriteEnable = (op_r == OP_JAL);
        link           = (op_r == OP_JAL);
        retire_s       = 1'b1;
      end
      S_BRANCH: begin
        pcWrite    = cond_le;
        pcSrc      = 2'd1;
        ALUControl = op_r[5:1];
        retire_s   = 1'b1;
      end
      default: begin
        mem_req  = 1'b0;
        retire_s = 1'b0;
      end
    endcase
  end

  assign retired = retired_r;
  assign state   = state_r;

endmodule
